// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: BLANK/SHOW slots per digit, double-buffered display word.
// Latency: seg_o/an_o/frame_o registered, one cycle behind FSM. Backpressure: ready_o low while a word is pending swap.
module hex_scan_ctrl #(
    parameter int N_DIGITS     = 8,
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk_50m,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [N_DIGITS-1:0]   digit_en_i,
    output logic [6:0]            seg_o,
    output logic [N_DIGITS-1:0]   an_o,
    output logic                  frame_o
);

    localparam int MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [0:0]    ST_BLANK = 1'b0;
    localparam logic [0:0]    ST_SHOW  = 1'b1;
    localparam logic [CW-1:0] DIG_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    logic [0:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] active_q, active_d;
    logic [4*N_DIGITS-1:0] pend_q, pend_d;
    logic                  pflag_q, pflag_d;
    logic [6:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  frame_q, frame_d;
    logic                  slot_last;
    logic                  boundary;
    logic [3:0]            cur_nib;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_last = (state_q == ST_SHOW) ? (cnt_q == DIG_LAST) : (cnt_q == BLK_LAST);
        boundary  = slot_last && (state_q == ST_SHOW) && (idx_q == IDX_LAST);

        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CW'(1);
        if (slot_last) begin
            cnt_d   = '0;
            state_d = (state_q == ST_SHOW) ? ST_BLANK : ST_SHOW;
            if (state_q == ST_SHOW) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end
        end

        // Swap reads the pre-edge pending word; a same-edge capture waits for the next frame.
        active_d = active_q;
        pend_d   = pend_q;
        pflag_d  = pflag_q;
        if (boundary && pflag_q) begin
            active_d = pend_q;
            pflag_d  = 1'b0;
        end
        if (valid_i && !pflag_q) begin
            pend_d  = data_i;
            pflag_d = 1'b1;
        end

        cur_nib = active_q[4*idx_q +: 4];
        an_d    = '1;
        seg_d   = 7'h7F;
        if (state_q == ST_SHOW) begin
            an_d[idx_q] = ~digit_en_i[idx_q];
            if (digit_en_i[idx_q]) begin
                seg_d = decode(cur_nib);
            end
        end

        frame_d = boundary;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_BLANK;
            cnt_q    <= '0;
            idx_q    <= '0;
            active_q <= '0;
            pend_q   <= '0;
            pflag_q  <= 1'b0;
            seg_q    <= 7'h7F;
            an_q     <= '1;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            pflag_q  <= pflag_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            frame_q  <= frame_d;
        end
    end

    assign ready_o = ~pflag_q;
    assign seg_o   = seg_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule
